// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// word geometry and the access fault check.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;

  // Misaligned byte address or word index beyond the end of the array.
  function automatic logic access_faults(input logic [31:0] addr,
                                         input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth_words));
  endfunction

endpackage

// File: rtl/data_memory_responder_wait_counter.sv
// Loadable 4-bit down-counter; holds at zero and flags done while zero.
module data_memory_responder_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       done
);

  logic [3:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == 4'd0);

endmodule

// File: rtl/data_memory_responder.sv
// Responder for the pipeline's data-memory port: one access in flight,
// fixed wait, commit on entry to RESPOND, one-cycle response pulse.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Request,
  input  logic        WriteEnable,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEnable,
  output logic        Ready,
  output logic        ResponseValid,
  output logic [31:0] ReadData,
  output logic        Error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e      state_d, state_q;
  logic        we_d, we_q;
  logic [31:0] addr_d, addr_q;
  logic [31:0] wdata_d, wdata_q;
  logic [3:0]  be_d, be_q;
  logic [31:0] read_data_d, read_data_q;
  logic        error_d, error_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept, commit, cnt_load, cnt_done;
  logic             c_we, c_fault, mem_we;
  logic [31:0]      c_addr, c_wdata, merged;
  logic [3:0]       c_be;
  logic [IDX_W-1:0] c_idx;

  data_memory_responder_wait_counter u_wait_counter (
    .clk        (CLK),
    .reset      (Reset),
    .load       (cnt_load),
    .load_value (4'(WAIT_CYCLES - 1)),
    .done       (cnt_done)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    read_data_d = 32'd0;
    error_d     = 1'b0;
    accept      = 1'b0;
    commit      = 1'b0;
    cnt_load    = 1'b0;

    case (state_q)
      ST_IDLE, ST_RESPOND: begin
        if (Request) begin
          accept  = 1'b1;
          we_d    = WriteEnable;
          addr_d  = Address;
          wdata_d = WriteData;
          be_d    = ByteEnable;
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = ST_RESPOND;
          end else begin
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_done) begin
          commit  = 1'b1;
          state_d = ST_RESPOND;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A zero-wait access commits on its own accept edge, before the latches fill.
    c_we    = accept ? WriteEnable : we_q;
    c_addr  = accept ? Address     : addr_q;
    c_wdata = accept ? WriteData   : wdata_q;
    c_be    = accept ? ByteEnable  : be_q;
    c_fault = access_faults(c_addr, DEPTH_WORDS);
    c_idx   = c_addr[IDX_W+1:2];

    merged = mem_q[c_idx];
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (c_be[i]) begin
        merged[8*i +: 8] = c_wdata[8*i +: 8];
      end
    end

    mem_we = commit && c_we && !c_fault && !Reset;

    if (commit) begin
      error_d = c_fault;
      if (!c_we && !c_fault) begin
        read_data_d = mem_q[c_idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      read_data_q <= 32'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      read_data_q <= read_data_d;
      error_q     <= error_d;
    end
  end

  // The array is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[c_idx] <= merged;
    end
  end

  assign Ready         = (state_q != ST_WAIT);
  assign ResponseValid = (state_q == ST_RESPOND);
  assign ReadData      = read_data_q;
  assign Error         = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: a 2-wait-cycle instance for the main scenarios and a
// zero-wait instance for back-to-back streaming.
module tb_data_memory_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t exp2_q[$];
  exp_t exp0_q[$];
  exp_t mon2_e, mon0_e;

  logic        rst2 = 1'b1, req2 = 1'b0, we2 = 1'b0;
  logic [31:0] addr2 = '0, wd2 = '0;
  logic [3:0]  be2 = '0;
  logic        rdy2, rv2, err2;
  logic [31:0] rd2;

  logic        rst0 = 1'b1, req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wd0 = '0;
  logic [3:0]  be0 = '0;
  logic        rdy0, rv0, err0;
  logic [31:0] rd0;

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
    .CLK(clk), .Reset(rst2), .Request(req2), .WriteEnable(we2),
    .Address(addr2), .WriteData(wd2), .ByteEnable(be2),
    .Ready(rdy2), .ResponseValid(rv2), .ReadData(rd2), .Error(err2)
  );

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .Reset(rst0), .Request(req0), .WriteEnable(we0),
    .Address(addr0), .WriteData(wd0), .ByteEnable(be0),
    .Ready(rdy0), .ResponseValid(rv0), .ReadData(rd0), .Error(err0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitors pop expectations whenever a response pulse is presented.
  always @(negedge clk) begin
    if (!rst2) begin
      if (rv2) begin
        if (exp2_q.size() == 0) begin
          checkOutput("w2_unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon2_e = exp2_q.pop_front();
          checkOutput("w2_rdata", rd2, mon2_e.rdata);
          checkOutput("w2_error", 32'(err2), 32'(mon2_e.err));
          checkOutput("w2_latency", 32'(cyc - mon2_e.acc_cyc), 32'd3);
        end
      end else begin
        checkOutput("w2_idle_outputs", {rd2[31:1], rd2[0] | err2}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst0) begin
      if (rv0) begin
        if (exp0_q.size() == 0) begin
          checkOutput("w0_unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon0_e = exp0_q.pop_front();
          checkOutput("w0_rdata", rd0, mon0_e.rdata);
          checkOutput("w0_error", 32'(err0), 32'(mon0_e.err));
          checkOutput("w0_latency", 32'(cyc - mon0_e.acc_cyc), 32'd1);
        end
      end else begin
        checkOutput("w0_idle_outputs", {rd0[31:1], rd0[0] | err0}, 32'd0);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [3:0] be,
                               input logic [31:0] exp_rd, input logic exp_err);
    int guard = 0;
    @(negedge clk);
    req2 = 1'b1; we2 = we; addr2 = addr; wd2 = wd; be2 = be;
    while (!rdy2 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy2) begin
      checkOutput("w2_accept_timeout", 32'd0, 32'd1);
    end else begin
      exp2_q.push_back('{rdata: exp_rd, err: exp_err, acc_cyc: cyc});
    end
    @(posedge clk);
    #1 req2 = 1'b0;
  endtask

  task automatic waitDrain2();
    int guard = 0;
    while (exp2_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("w2_drain", 32'(exp2_q.size()), 32'd0);
    exp2_q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v_addr [5];
    logic [31:0] v_wd   [5];
    logic        v_we   [5];
    logic [31:0] v_rd   [5];
    logic        v_err  [5];

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    rst0 = 1'b0;
    checkOutput("reset_ready", 32'(rdy2), 32'd1);
    checkOutput("reset_rvalid", 32'(rv2), 32'd0);
    checkOutput("reset_rdata", rd2, 32'd0);
    checkOutput("reset_error", 32'(err2), 32'd0);

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEAA, 1'b0);
    applyStimulus(1'b1, 32'h10, 32'h12345678, 4'b0000, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0);
    applyStimulus(1'b1, 32'h10, 32'hCAFEF00D, 4'b1100, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'b0000, 32'hCAFEBEAA, 1'b0);
    applyStimulus(1'b0, 32'h12, 32'h0, 4'b0000, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h400, 32'h0, 4'b0000, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h13, 32'h11223344, 4'b1111, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'b0000, 32'hCAFEBEAA, 1'b0);
    applyStimulus(1'b1, 32'h3FC, 32'hA5A5A5A5, 4'b1111, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h3FC, 32'h0, 4'b0000, 32'hA5A5A5A5, 1'b0);
    applyStimulus(1'b1, 32'h0, 32'h01020304, 4'b1111, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'b0000, 32'h01020304, 1'b0);
    applyStimulus(1'b1, 32'h20, 32'h55667788, 4'b1111, 32'h0, 1'b0);
    waitDrain2();

    // Abort a store on the cycle just before it would have committed.
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wd2 = 32'h11111111; be2 = 4'b1111;
    @(posedge clk);
    #1 req2 = 1'b0;
    @(negedge clk);
    checkOutput("abort_wait_ready_low", 32'(rdy2), 32'd0);
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", 32'(rdy2), 32'd1);
    checkOutput("abort_rvalid", 32'(rv2), 32'd0);
    checkOutput("abort_rdata", rd2, 32'd0);
    rst2 = 1'b0;
    applyStimulus(1'b0, 32'h20, 32'h0, 4'b0000, 32'h55667788, 1'b0);
    waitDrain2();

    v_we = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    v_addr = '{32'h8, 32'h8, 32'hC, 32'hC, 32'h6};
    v_wd = '{32'h0000BEEF, 32'h0, 32'h12340000, 32'h0, 32'h0};
    v_rd = '{32'h0, 32'h0000BEEF, 32'h0, 32'h12340000, 32'h0};
    v_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req0 = 1'b1; we0 = v_we[i]; addr0 = v_addr[i]; wd0 = v_wd[i]; be0 = 4'b1111;
      exp0_q.push_back('{rdata: v_rd[i], err: v_err[i], acc_cyc: cyc});
      @(negedge clk);
      checkOutput("w0_rvalid_continuous", 32'(rv0), 32'd1);
    end
    req0 = 1'b0;
    @(negedge clk);
    checkOutput("w0_back_to_idle", 32'(rv0), 32'd0);
    checkOutput("w0_drain", 32'(exp0_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
